// File: rtl/regfile_decoded.sv
// regfile_decoded: NREG x DATA_W register file with a one-hot decoded write
// select (Wordline), one write port and two combinational read ports.
// Register 0 is hardwired to zero when ZERO_REG0 = 1.
// Optional feature macro REGFILE_BYPASS_EN: when defined, a read of the
// register being written in the same cycle returns DstData (write-before-read).
// When undefined, such a read returns the value stored before the edge.
module regfile_decoded #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int ZERO_REG0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WriteReg,
  input  logic [ADDR_W-1:0]        DstReg,
  input  logic [DATA_W-1:0]        DstData,
  input  logic [ADDR_W-1:0]        SrcReg1,
  input  logic [ADDR_W-1:0]        SrcReg2,
  output logic [DATA_W-1:0]        SrcData1,
  output logic [DATA_W-1:0]        SrcData2,
  output logic [(2**ADDR_W)-1:0]   Wordline
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  // Write select decode: at most one bit set; bit 0 suppressed for a zero register.
  always_comb begin
    Wordline = '0;
    for (int i = 0; i < NREG; i++) begin
      Wordline[i] = WriteReg && (DstReg == ADDR_W'(i));
    end
    if (ZERO_REG0 != 0) begin
      Wordline[0] = 1'b0;
    end
  end

  // Storage array: async clear, each register loads only when its wordline is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (Wordline[i]) begin
          regs[i] <= DstData;
        end
      end
    end
  end

  // Read port 1: stored value, optional same-cycle forward, then zero overrides.
  always_comb begin
    SrcData1 = regs[SrcReg1];
`ifdef REGFILE_BYPASS_EN
    if (Wordline[SrcReg1]) begin
      SrcData1 = DstData;
    end
`endif
    if (rst || ((ZERO_REG0 != 0) && (SrcReg1 == '0))) begin
      SrcData1 = '0;
    end
  end

  // Read port 2: identical structure to port 1, fully independent.
  always_comb begin
    SrcData2 = regs[SrcReg2];
`ifdef REGFILE_BYPASS_EN
    if (Wordline[SrcReg2]) begin
      SrcData2 = DstData;
    end
`endif
    if (rst || ((ZERO_REG0 != 0) && (SrcReg2 == '0))) begin
      SrcData2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// Testbench for regfile_decoded (DATA_W=16, ADDR_W=4, ZERO_REG0=1).
// Table of directed vectors, hand sequences for reset/bypass/fill corners,
// and random traffic against an array-based reference model.
module tb_regfile_decoded;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  dst;
  logic [15:0] data;
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [15:0] d1;
  logic [15:0] d2;
  logic [15:0] wl;

  int n_cmp;
  int n_err;

  logic [15:0] mdl [16];

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] exp_wl;
    logic [15:0] exp_d1;
    logic [15:0] exp_d2;
  } vec_t;

  vec_t vecs [9];

  regfile_decoded #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .WriteReg (we),
    .DstReg   (dst),
    .DstData  (data),
    .SrcReg1  (s1),
    .SrcReg2  (s2),
    .SrcData1 (d1),
    .SrcData2 (d2),
    .Wordline (wl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: register contents as an array, reads by rule
  function automatic logic [15:0] m_read(input logic [3:0] idx);
    if (rst || idx == 4'd0) return 16'h0000;
    if (BYP && we && dst == idx) return data;
    return mdl[idx];
  endfunction

  function automatic logic [15:0] m_wl();
    if (!we || dst == 4'd0) return 16'h0000;
    return 16'h0001 << dst;
  endfunction

  // advance one clock edge, update the model, leave inputs stable 1ns later
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    end else if (we && dst != 4'd0) begin
      mdl[dst] = data;
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] d, input logic [15:0] v,
                       input logic [3:0] a, input logic [3:0] b);
    we = w; dst = d; data = v; s1 = a; s2 = b;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_wl"}, wl, m_wl());
    chk({tag, "_d1"}, d1, m_read(s1));
    chk({tag, "_d2"}, d2, m_read(s2));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;

    vecs[0] = '{1'b1, 4'd9,  16'hBEEF, 4'd8,  4'd10, 16'h0200, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 4'd9,  16'h0000, 4'd9,  4'd10, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd9,  16'h0000, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 4'd15, 16'hA5A5, 4'd9,  4'd9,  16'h8000, 16'hBEEF, 16'hBEEF};
    vecs[5] = '{1'b1, 4'd1,  16'h0001, 4'd15, 4'd8,  16'h0002, 16'hA5A5, 16'h0000};
    vecs[6] = '{1'b0, 4'd5,  16'h7777, 4'd1,  4'd15, 16'h0000, 16'h0001, 16'hA5A5};
    vecs[7] = '{1'b1, 4'd8,  16'h1111, 4'd9,  4'd10, 16'h0100, 16'hBEEF, 16'h0000};
    vecs[8] = '{1'b0, 4'd0,  16'h0000, 4'd8,  4'd10, 16'h0000, 16'h1111, 16'h0000};

    // reset state; a write attempt during reset must be discarded
    rst = 1'b1;
    drive(1'b1, 4'd4, 16'h4444, 4'd4, 4'd7);
    #2;
    chk("rst_wl_decode", wl, 16'h0010);
    chk("rst_d1", d1, 16'h0000);
    chk("rst_d2", d2, 16'h0000);
    cycle();
    drive(1'b0, 4'd0, 16'h0, 4'd4, 4'd4);
    rst = 1'b0;
    #1;
    chk("rst_write_dropped", d1, 16'h0000);

    // directed table; first vector writes at the first edge after reset release
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].we, vecs[k].dst, vecs[k].data, vecs[k].s1, vecs[k].s2);
      @(negedge clk);
      chk($sformatf("vec%0d_wl", k), wl, vecs[k].exp_wl);
      chk($sformatf("vec%0d_d1", k), d1, vecs[k].exp_d1);
      chk($sformatf("vec%0d_d2", k), d2, vecs[k].exp_d2);
      cycle();
    end

    // write disabled sweep: no wordline, array unchanged
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'(k), 16'(32'hF0F0 + k), 4'(k), 4'(15 - k));
      @(negedge clk);
      check_model($sformatf("nowr%0d", k));
      cycle();
    end

    // same-cycle read of the register being written
    drive(1'b1, 4'd3, 16'h00AA, 4'd0, 4'd0);
    cycle();
    drive(1'b1, 4'd3, 16'h5555, 4'd3, 4'd3);
    @(negedge clk);
    chk("same_cycle_d1", d1, BYP ? 16'h5555 : 16'h00AA);
    chk("same_cycle_d2", d2, BYP ? 16'h5555 : 16'h00AA);
    cycle();
    drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
    @(negedge clk);
    chk("next_cycle_d1", d1, 16'h5555);
    chk("next_cycle_d2", d2, 16'h5555);
    cycle();

    // fill R1..R15 (and try R0), then read every pair
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'(k), 16'(32'h1000 + k), 4'd0, 4'd0);
      cycle();
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(j));
        @(negedge clk);
        chk("fill_d1", d1, (i == 0) ? 16'h0000 : 16'(32'h1000 + i));
        chk("fill_d2", d2, (j == 0) ? 16'h0000 : 16'(32'h1000 + j));
        cycle();
      end
    end

    // async reset mid-cycle clears R5 before any clock edge
    drive(1'b1, 4'd5, 16'h1234, 4'd5, 4'd6);
    cycle();
    drive(1'b0, 4'd0, 16'h0, 4'd5, 4'd6);
    @(negedge clk);
    chk("pre_rst_r5", d1, 16'h1234);
    rst = 1'b1;
    #1;
    chk("async_rst_r5", d1, 16'h0000);
    chk("async_rst_r6", d2, 16'h0000);
    cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_r5", d1, 16'h0000);
    chk("post_rst_r6", d2, 16'h0000);
    drive(1'b1, 4'd7, 16'h7A7A, 4'd7, 4'd5);
    cycle();
    drive(1'b0, 4'd0, 16'h0, 4'd7, 4'd5);
    @(negedge clk);
    chk("first_write_after_rst", d1, 16'h7A7A);
    cycle();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) s2 = s1;
      @(negedge clk);
      check_model("rand");
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
